// File: rtl/axis_img_frame_rx.sv
// Receives a DMA control packet carrying frame geometry, then re-frames the
// following MM2S pixel beats as a video stream (tuser = start of frame, tlast = end of line).
module axis_img_frame_rx #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          CNTRL_WIDTH = 32,
    parameter logic [31:0] HDR_TAG     = 32'hA0000000
) (
    input  logic                     s_axis_mm2s_aclk,
    input  logic                     s_axis_mm2s_areset,
    input  logic                     s_axis_cntrl_tvalid,
    output logic                     s_axis_cntrl_tready,
    input  logic                     s_axis_cntrl_tlast,
    input  logic [CNTRL_WIDTH-1:0]   s_axis_cntrl_tdata,
    input  logic [CNTRL_WIDTH/8-1:0] s_axis_cntrl_tkeep,
    input  logic                     s_axis_mm2s_tvalid,
    output logic                     s_axis_mm2s_tready,
    input  logic [DATA_WIDTH-1:0]    s_axis_mm2s_tdata,
    input  logic [DATA_WIDTH/8-1:0]  s_axis_mm2s_tkeep,
    input  logic                     s_axis_mm2s_tlast,
    output logic                     m_axis_video_tvalid,
    input  logic                     m_axis_video_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_video_tdata,
    output logic                     m_axis_video_tuser,
    output logic                     m_axis_video_tlast,
    output logic [11:0]              img_width,
    output logic [11:0]              img_height,
    output logic                     frame_busy,
    output logic                     frame_done,
    output logic                     hdr_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CNTRL = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_first;
    logic [11:0]             r_width;
    logic [11:0]             r_height;
    logic [11:0]             r_x;
    logic [11:0]             r_y;
    logic                    r_cntrl_rdy;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic                    r_vvalid;
    logic [DATA_WIDTH-1:0]   r_vdata;
    logic                    r_vuser;
    logic                    r_vlast;

    logic                    w_cntrl_fire;
    logic                    w_mm2s_rdy;
    logic                    w_pix_fire;
    logic                    w_tag_ok;
    logic [11:0]             w_geom_w;
    logic [11:0]             w_geom_h;
    logic                    w_geom_zero;
    logic                    w_x_end;
    logic                    w_y_end;
    logic                    w_err_nxt;
    logic                    w_done_nxt;
    logic                    w_frame_start;
    logic                    w_unused;

    // Sideband that carries no information here: framing is purely count-based.
    assign w_unused = ^{s_axis_cntrl_tkeep, s_axis_mm2s_tkeep, s_axis_mm2s_tlast};

    assign w_cntrl_fire = s_axis_cntrl_tvalid && r_cntrl_rdy;
    assign w_mm2s_rdy   = (r_state == S_DATA) && (!r_vvalid || m_axis_video_tready);
    assign w_pix_fire   = s_axis_mm2s_tvalid && w_mm2s_rdy;
    assign w_tag_ok     = (s_axis_cntrl_tdata[31:0] == HDR_TAG);
    // A tlast on word 1 must be judged on that beat's geometry, not the stale latch.
    assign w_geom_h     = r_first ? s_axis_cntrl_tdata[31:20] : r_height;
    assign w_geom_w     = r_first ? s_axis_cntrl_tdata[19:8]  : r_width;
    assign w_geom_zero  = (w_geom_w == 12'd0) || (w_geom_h == 12'd0);
    assign w_x_end      = (r_x == r_width - 12'd1);
    assign w_y_end      = (r_y == r_height - 12'd1);

    always_ff @(posedge s_axis_mm2s_aclk or posedge s_axis_mm2s_areset) begin
        if (s_axis_mm2s_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cntrl_fire && !s_axis_cntrl_tlast) begin
                    w_state_nxt = w_tag_ok ? S_CNTRL : S_DRAIN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CNTRL: begin
                if (w_cntrl_fire && s_axis_cntrl_tlast) begin
                    w_state_nxt = w_geom_zero ? S_IDLE : S_DATA;
                end else begin
                    w_state_nxt = S_CNTRL;
                end
            end
            S_DRAIN: begin
                if (w_cntrl_fire && s_axis_cntrl_tlast) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DATA: begin
                if (w_pix_fire && w_x_end && w_y_end) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_err_nxt     = 1'b0;
        w_done_nxt    = 1'b0;
        w_frame_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cntrl_fire) begin
                    w_err_nxt = !w_tag_ok || s_axis_cntrl_tlast;
                end else begin
                    w_err_nxt = 1'b0;
                end
            end
            S_CNTRL: begin
                if (w_cntrl_fire && s_axis_cntrl_tlast) begin
                    w_err_nxt     = w_geom_zero;
                    w_frame_start = !w_geom_zero;
                end else begin
                    w_err_nxt     = 1'b0;
                    w_frame_start = 1'b0;
                end
            end
            S_DATA: begin
                if (w_pix_fire) begin
                    w_done_nxt = w_x_end && w_y_end;
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            default: begin
                w_err_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge s_axis_mm2s_aclk or posedge s_axis_mm2s_areset) begin
        if (s_axis_mm2s_areset) begin
            r_cntrl_rdy <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cntrl_rdy <= (w_state_nxt != S_DATA);
            r_busy      <= (w_state_nxt == S_DATA);
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_ff @(posedge s_axis_mm2s_aclk or posedge s_axis_mm2s_areset) begin
        if (s_axis_mm2s_areset) begin
            r_first  <= 1'b0;
            r_width  <= 12'd0;
            r_height <= 12'd0;
        end else if (w_cntrl_fire && (r_state == S_IDLE)) begin
            r_first <= w_tag_ok && !s_axis_cntrl_tlast;
        end else if (w_cntrl_fire && (r_state == S_CNTRL)) begin
            r_first <= 1'b0;
            if (r_first) begin
                r_height <= s_axis_cntrl_tdata[31:20];
                r_width  <= s_axis_cntrl_tdata[19:8];
            end
        end
    end

    always_ff @(posedge s_axis_mm2s_aclk or posedge s_axis_mm2s_areset) begin
        if (s_axis_mm2s_areset) begin
            r_x <= 12'd0;
            r_y <= 12'd0;
        end else if (w_frame_start) begin
            r_x <= 12'd0;
            r_y <= 12'd0;
        end else if (w_pix_fire) begin
            if (w_x_end) begin
                r_x <= 12'd0;
                r_y <= r_y + 12'd1;
            end else begin
                r_x <= r_x + 12'd1;
            end
        end
    end

    // Single-entry output register; a load in the same cycle as a drain keeps it full.
    always_ff @(posedge s_axis_mm2s_aclk or posedge s_axis_mm2s_areset) begin
        if (s_axis_mm2s_areset) begin
            r_vvalid <= 1'b0;
            r_vdata  <= {DATA_WIDTH{1'b0}};
            r_vuser  <= 1'b0;
            r_vlast  <= 1'b0;
        end else if (w_pix_fire) begin
            r_vvalid <= 1'b1;
            r_vdata  <= s_axis_mm2s_tdata;
            r_vuser  <= (r_x == 12'd0) && (r_y == 12'd0);
            r_vlast  <= w_x_end;
        end else if (m_axis_video_tready) begin
            r_vvalid <= 1'b0;
        end
    end

    assign s_axis_cntrl_tready = r_cntrl_rdy;
    assign s_axis_mm2s_tready  = w_mm2s_rdy;
    assign m_axis_video_tvalid = r_vvalid;
    assign m_axis_video_tdata  = r_vdata;
    assign m_axis_video_tuser  = r_vuser;
    assign m_axis_video_tlast  = r_vlast;
    assign img_width           = r_width;
    assign img_height          = r_height;
    assign frame_busy          = r_busy;
    assign frame_done          = r_done;
    assign hdr_err             = r_err;

endmodule

// File: tb/tb_axis_img_frame_rx.sv
// Randomized bench for axis_img_frame_rx with a packet/frame-level reference model.
module tb_axis_img_frame_rx;

    localparam logic [31:0] TAG = 32'hA0000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cvalid = 1'b0, cready, clast = 1'b0;
    logic [31:0] cdata = 32'd0;
    logic        pvalid = 1'b0, pready, plast = 1'b0;
    logic [31:0] pdata = 32'd0;
    logic        vvalid, vready = 1'b0, vuser, vlast;
    logic [31:0] vdata;
    logic [11:0] img_w, img_h;
    logic        busy, done, err;

    always #5 clk = ~clk;

    axis_img_frame_rx dut (
        .s_axis_mm2s_aclk    (clk),
        .s_axis_mm2s_areset  (rst),
        .s_axis_cntrl_tvalid (cvalid),
        .s_axis_cntrl_tready (cready),
        .s_axis_cntrl_tlast  (clast),
        .s_axis_cntrl_tdata  (cdata),
        .s_axis_cntrl_tkeep  (4'hF),
        .s_axis_mm2s_tvalid  (pvalid),
        .s_axis_mm2s_tready  (pready),
        .s_axis_mm2s_tdata   (pdata),
        .s_axis_mm2s_tkeep   (4'hF),
        .s_axis_mm2s_tlast   (plast),
        .m_axis_video_tvalid (vvalid),
        .m_axis_video_tready (vready),
        .m_axis_video_tdata  (vdata),
        .m_axis_video_tuser  (vuser),
        .m_axis_video_tlast  (vlast),
        .img_width           (img_w),
        .img_height          (img_h),
        .frame_busy          (busy),
        .frame_done          (done),
        .hdr_err             (err)
    );

    typedef struct { logic [31:0] d; logic l; } cw_t;
    typedef struct { logic [31:0] d; logic u; logic l; } beat_t;

    cw_t         cq[$];
    logic [31:0] pq[$];
    beat_t       expq[$];
    beat_t       obs[$];

    int checks = 0, failures = 0;
    int cyc = 0, since_rst = 0;
    bit c_fire = 0, p_fire = 0;
    int vr_mode = 0, c_rate = 100, p_rate = 100;

    // reference model state
    int          m_idx = 0, m_w = 0, m_h = 0, m_pix = 0;
    logic [31:0] m_w0 = 32'd0, m_g = 32'd0;
    bit          m_in_frame = 0;
    int          done_at = -1, err_at = -1;
    int          n_done = 0, n_err = 0, first_acc = 0, last_acc = 0;
    bit          prev_stall = 0, prev_pfire = 0;
    beat_t       held;
    logic [31:0] last_pix = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        beat_t cur, e;
        cyc++;
        if (rst) begin
            since_rst = 0; c_fire = 0; p_fire = 0;
            m_idx = 0; m_in_frame = 0; m_pix = 0; done_at = -1; err_at = -1;
            expq.delete(); prev_stall = 0; prev_pfire = 0;
        end else begin
            since_rst++;
            chk("frame_done", done, cyc == done_at);
            chk("hdr_err", err, cyc == err_at);
            if (done) n_done++;
            if (err) n_err++;
            chk("mm2s_tready", pready, m_in_frame && (!vvalid || vready));
            chk("frame_busy", busy, m_in_frame);
            if (m_in_frame) chk("cntrl_tready_busy", cready, 1'b0);
            else if (since_rst >= 2) chk("cntrl_tready_idle", cready, 1'b1);
            if (m_in_frame) begin
                chk("img_width", img_w, m_w);
                chk("img_height", img_h, m_h);
            end
            cur.d = vdata; cur.u = vuser; cur.l = vlast;
            if (prev_pfire) begin
                chk("latency_valid", vvalid, 1'b1);
                chk("latency_data", vdata, last_pix);
            end else if (prev_stall) begin
                chk("stall_valid", vvalid, 1'b1);
                chk("stall_beat", {cur.d, cur.u, cur.l}, {held.d, held.u, held.l});
            end
            if (vvalid && vready) begin
                obs.push_back(cur);
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat", vdata);
                end else begin
                    e = expq.pop_front();
                    chk("video_beat", {cur.d, cur.u, cur.l}, {e.d, e.u, e.l});
                end
            end
            prev_stall = vvalid && !vready;
            held = cur;
            c_fire = cvalid && cready;
            p_fire = pvalid && pready;
            if (p_fire && m_in_frame) begin
                e.d = pdata; e.u = (m_pix == 0); e.l = ((m_pix % m_w) == m_w - 1);
                expq.push_back(e);
                if (m_pix == 0) first_acc = cyc;
                last_acc = cyc;
                last_pix = pdata;
                m_pix++;
                if (m_pix == m_w * m_h) begin
                    m_in_frame = 0;
                    done_at = cyc + 1;
                end
            end
            if (c_fire) begin
                if (m_idx == 0) begin
                    m_w0 = cdata;
                    if (cdata != TAG || clast) err_at = cyc + 1;
                end else if (m_w0 == TAG) begin
                    if (m_idx == 1) m_g = cdata;
                    if (clast) begin
                        if (m_g[31:20] == 12'd0 || m_g[19:8] == 12'd0) err_at = cyc + 1;
                        else begin
                            m_in_frame = 1; m_h = int'(m_g[31:20]); m_w = int'(m_g[19:8]); m_pix = 0;
                        end
                    end
                end
                m_idx = clast ? 0 : m_idx + 1;
            end
            prev_pfire = p_fire;
        end
    end

    task automatic step();
        @(posedge clk); #1;
        if (c_fire && cq.size() > 0) cq.delete(0);
        if (p_fire && pq.size() > 0) pq.delete(0);
        if (!(cvalid && !c_fire)) cvalid = (cq.size() > 0) && (int'($urandom_range(99)) < c_rate);
        if (cvalid) begin cdata = cq[0].d; clast = cq[0].l; end
        if (!(pvalid && !p_fire)) pvalid = (pq.size() > 0) && (int'($urandom_range(99)) < p_rate);
        if (pvalid) begin pdata = pq[0]; plast = 1'($urandom_range(1)); end
        case (vr_mode)
            0: vready = 1'b1;
            1: vready = 1'($urandom_range(1));
            2: vready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: vready = 1'b1;
        endcase
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((cq.size() > 0 || pq.size() > 0 || expq.size() > 0 || vvalid) && n < budget) begin
            step(); n++;
        end
        if (n >= budget) begin
            checks++; failures++;
            $display("FAIL timeout: got %0d cycles expected fewer than %0d", n, budget);
        end
        repeat (3) step();
    endtask

    task automatic push_pkt(input logic [31:0] w0, input logic [11:0] h, input logic [11:0] w, input int extra);
        cw_t c;
        c.d = w0; c.l = 1'b0; cq.push_back(c);
        c.d = {h, w, 8'h00}; c.l = (extra == 0); cq.push_back(c);
        for (int k = 0; k < extra; k++) begin
            c.d = TAG + 32'(k + 3); c.l = (k == extra - 1); cq.push_back(c);
        end
    endtask

    task automatic push_pix(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) pq.push_back(base + 32'(k));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, {vvalid, vuser, vlast, pready, cready, busy, done, err}, 8'd0);
        chk({tag, "_vdata"}, vdata, 32'd0);
        chk({tag, "_geom"}, {img_w, img_h}, 24'd0);
    endtask

    initial begin
        int d0, e0, nt, nu, sum, frames;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // T1: 4x2 frame, free-flowing output
        obs.delete(); d0 = n_done; vr_mode = 0; c_rate = 100; p_rate = 100;
        push_pkt(TAG, 12'd2, 12'd4, 4); push_pix(8, 32'd1);
        run_until_idle(200);
        chk("t1_count", obs.size(), 8);
        if (obs.size() == 8) begin
            chk("t1_first", {obs[0].d, obs[0].u, obs[0].l}, {32'd1, 1'b1, 1'b0});
            chk("t1_eol1", {obs[3].d, obs[3].u, obs[3].l}, {32'd4, 1'b0, 1'b1});
            chk("t1_sol2", {obs[4].d, obs[4].u, obs[4].l}, {32'd5, 1'b0, 1'b0});
            chk("t1_last", {obs[7].d, obs[7].u, obs[7].l}, {32'd8, 1'b0, 1'b1});
        end
        chk("t1_done", n_done - d0, 1);
        chk("t1_geom", {img_w, img_h}, {12'd4, 12'd2});

        // T2: same frame with tready 1-0-0-1
        obs.delete(); d0 = n_done; vr_mode = 2;
        push_pkt(TAG, 12'd2, 12'd4, 4); push_pix(8, 32'd1);
        run_until_idle(300);
        sum = 0;
        foreach (obs[i]) sum += int'(obs[i].d);
        chk("t2_count", obs.size(), 8);
        chk("t2_sum", sum, 36);
        chk("t2_done", n_done - d0, 1);

        // T3: bad tag, drained, then a good packet
        obs.delete(); d0 = n_done; e0 = n_err; vr_mode = 1; c_rate = 60; p_rate = 70;
        push_pkt(32'hB0000000, 12'd2, 12'd4, 4);
        push_pkt(TAG, 12'd2, 12'd4, 1); push_pix(8, 32'd1);
        run_until_idle(400);
        chk("t3_err", n_err - e0, 1);
        chk("t3_done", n_done - d0, 1);
        chk("t3_count", obs.size(), 8);

        // T4: zero width, single-word header, then 1x1 frame with tlast on word 1
        obs.delete(); d0 = n_done; e0 = n_err;
        push_pkt(TAG, 12'd2, 12'd0, 2);
        begin cw_t c; c.d = TAG; c.l = 1'b1; cq.push_back(c); end
        run_until_idle(200);
        chk("t4_err", n_err - e0, 2);
        chk("t4_nobeats", obs.size(), 0);
        push_pkt(TAG, 12'd1, 12'd1, 0); push_pix(1, 32'h55);
        run_until_idle(200);
        chk("t4_count", obs.size(), 1);
        if (obs.size() == 1) chk("t4_beat", {obs[0].d, obs[0].u, obs[0].l}, {32'h55, 1'b1, 1'b1});
        chk("t4_done", n_done - d0, 1);

        // T5: reset after 3 of 8 pixels
        obs.delete(); d0 = n_done; vr_mode = 0; c_rate = 100; p_rate = 100;
        push_pkt(TAG, 12'd2, 12'd4, 0); push_pix(8, 32'd1);
        begin
            int n = 0;
            while (!(m_in_frame && m_pix >= 3) && n < 100) begin step(); n++; end
            chk("t5_reach3", m_pix, 3);
        end
        rst = 1'b1; #1;
        check_all_zero("t5_reset");
        cq.delete(); pq.delete(); cvalid = 1'b0; pvalid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (4) step();
        chk("t5_nodone", n_done - d0, 0);
        obs.delete();
        push_pkt(TAG, 12'd2, 12'd4, 4); push_pix(8, 32'd101);
        run_until_idle(200);
        chk("t5_count", obs.size(), 8);
        if (obs.size() == 8) begin
            chk("t5_first", {obs[0].d, obs[0].u}, {32'd101, 1'b1});
            chk("t5_last", {obs[7].d, obs[7].l}, {32'd108, 1'b1});
        end
        chk("t5_done", n_done - d0, 1);

        // T6: 640x48 frame at full rate
        obs.delete(); d0 = n_done;
        push_pkt(TAG, 12'd48, 12'd640, 4); push_pix(30720, 32'h1000);
        run_until_idle(40000);
        nt = 0; nu = 0;
        foreach (obs[i]) begin nt += int'(obs[i].l); nu += int'(obs[i].u); end
        chk("t6_count", obs.size(), 30720);
        chk("t6_tlast", nt, 48);
        chk("t6_tuser", nu, 1);
        chk("t6_rate", last_acc - first_acc, 30719);
        chk("t6_done", n_done - d0, 1);

        // T7: random small frames, random handshakes
        d0 = n_done; frames = 0;
        for (int f = 0; f < 10; f++) begin
            int w, h;
            w = int'($urandom_range(1, 7)); h = int'($urandom_range(1, 5));
            vr_mode = int'($urandom_range(0, 2));
            c_rate = int'($urandom_range(30, 100)); p_rate = int'($urandom_range(30, 100));
            if ($urandom_range(3) == 0) push_pkt(32'hC0000000 | $urandom, 12'd3, 12'd3, int'($urandom_range(0, 3)));
            push_pkt(TAG, 12'(h), 12'(w), int'($urandom_range(0, 4)));
            for (int k = 0; k < w * h; k++) pq.push_back($urandom);
            frames++;
            run_until_idle(2000);
        end
        chk("t7_done", n_done - d0, frames);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_img_frame_rx.md
# axis_img_frame_rx

Receive-side counterpart of the DMA control/MM2S stream pair. It consumes the 6-word control packet on the control AXI-Stream and extracts image height and width. It then accepts exactly width×height pixel beats from the MM2S data stream and re-emits them as a framed video stream: tuser marks start-of-frame, tlast marks end-of-line. It sits between the DMA (or its simulation model) and the image-processing pipeline.

## Interface
- DATA_WIDTH, 32, pixel beat width on MM2S input and video output
- CNTRL_WIDTH, 32, control word width (must be 32)
- HDR_TAG, 32'hA0000000, required value of control word 0
- s_axis_mm2s_aclk  in  1  sole clock; all logic on rising edge
- s_axis_mm2s_areset  in  1  reset, asynchronous, active-high
- s_axis_cntrl_tvalid / tready / tlast  in/out/in  1  control stream handshake
- s_axis_cntrl_tdata  in  CNTRL_WIDTH  control word
- s_axis_cntrl_tkeep  in  CNTRL_WIDTH/8  ignored
- s_axis_mm2s_tvalid / tready  in/out  1  pixel stream handshake
- s_axis_mm2s_tdata  in  DATA_WIDTH  pixel
- s_axis_mm2s_tkeep, s_axis_mm2s_tlast  in  DATA_WIDTH/8, 1  ignored (framing is count-based)
- m_axis_video_tvalid / tready  out/in  1  output handshake
- m_axis_video_tdata  out  DATA_WIDTH  pixel
- m_axis_video_tuser  out  1  start of frame (first pixel)
- m_axis_video_tlast  out  1  end of line (pixel x == width-1)
- img_width, img_height  out  12 each  latched frame geometry
- frame_busy  out  1  high in S_DATA
- frame_done  out  1  one-cycle pulse after last pixel accepted
- hdr_err  out  1  one-cycle pulse on malformed control packet

## Operation
- States: S_IDLE, S_CNTRL, S_DATA, S_DRAIN.
- s_axis_cntrl_tready = 1 in S_IDLE, S_CNTRL and S_DRAIN; 0 in S_DATA.
- S_IDLE: on a control beat:
  - If tdata == HDR_TAG and tlast = 0, go to S_CNTRL.
  - If tdata != HDR_TAG, pulse hdr_err and go to S_DRAIN, or stay in S_IDLE if tlast = 1.
  - If HDR_TAG with tlast = 1, pulse hdr_err and stay in S_IDLE.
- S_CNTRL: word 1 gives height = tdata[31:20] and width = tdata[19:8]; latch both into img_height/img_width.
  - Words 2..n are ignored.
  - On the tlast beat: if latched width = 0 or height = 0, pulse hdr_err and go to S_IDLE; else clear counters and go to S_DATA.
  - tlast on word 1 is legal; geometry is taken from that same beat.
- S_DRAIN: discard control beats until tlast, then go to S_IDLE.
- S_DATA:
  - s_axis_mm2s_tready = !m_axis_video_tvalid || m_axis_video_tready.
  - Each accepted beat loads the single output register: tdata; tuser = (x==0 && y==0); tlast = (x==width-1).
  - x increments and wraps to 0 at width-1; on wrap, y increments.
  - Accepting the pixel with x==width-1 and y==height-1 sets frame_done for the next cycle and returns to S_IDLE.
- Output register: m_axis_video_tvalid clears on m_axis_video_tready when no new beat is loaded in the same cycle. Load and drain in the same cycle keep tvalid = 1.
- s_axis_mm2s_tready = 0 outside S_DATA; extra pixels stall and are never dropped.
- Counters x, y are 12-bit and compare only against the latched geometry. Maximum frame is 4095×4095.

## Timing
- Async reset values: state S_IDLE; x, y = 0; img_width, img_height = 0; every output low (all treadys, m_axis_video_*, frame_busy, frame_done, hdr_err).
- Reset mid-frame aborts immediately: the output register is emptied and no partial-frame completion is signalled.
- Latency: pixel accepted at edge N appears on m_axis_video_* at edge N (valid in cycle N+1).
- Throughput: 1 pixel/clock with tready held high.
- frame_done and hdr_err are single-cycle, registered, asserted the cycle after the triggering beat.
- Transition S_CNTRL→S_DATA: mm2s tready can rise the cycle after the control tlast beat. No pixel is accepted in the same cycle as a control beat.
- The final output beat may still be pending in the register when frame_done pulses.
- S_IDLE may accept the next control packet while that beat is pending; the next frame's first pixel waits for the register to drain.
- m_axis_video_tdata/tuser/tlast are held stable while tvalid = 1 and tready = 0.

## Test plan
- Header {A0000000, {12'd2,12'd4,8'd0}, A0000003..A0000006 with tlast}, then pixels 1..8 -> output 1..8; tuser only on pixel 1; tlast on 4 and 8; frame_done one cycle after pixel 8 accepted; img_width=4, img_height=2.
- Same frame with m_axis_video_tready toggling 1-0-0-1 -> no pixel lost or duplicated; outputs stable during stall; s_axis_mm2s_tready low whenever register full and tready low.
- Word 0 = 32'hB0000000 in a 6-word packet -> hdr_err pulse; packet drained; s_axis_mm2s_tready stays 0; next valid packet processed normally.
- Header with width=0, and separately a 1-word HDR_TAG packet with tlast -> hdr_err, return to S_IDLE, no pixels accepted.
- Areset asserted after 3 of 8 pixels -> all outputs 0 immediately, no frame_done; a fresh header plus 8 pixels completes correctly.
- Geometry {480,640}, continuous input -> 307200 beats at one per clock, 480 tlast beats, single tuser, frame_done once.
